rf_bank_req_scheduler: RTL and testbench
========================================

Name: rf_bank_req_scheduler

Overview:
- Arbitrates operand-read requests from OC_NUM operand collectors.
- Steers each granted request's source reads into per-bank register-file request queues.
- Tracks per-bank queue occupancy with credit counters; never pushes into a full queue.
- Serialises two sources that fall into the same bank over two cycles; same-bank second entries are tagged so the bank datapath can pair the returning reads.

Parameters:
- OC_NUM, 4: number of operand collectors (2..8).
- NUM_BANKS, 4: number of RF banks, each with one request queue.
- QDEPTH, 8: entries per bank queue; equals initial credit.
- ROW_W, 3: physical row ID width.
- OCID_W, 3: collector ID field width in queue entry.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- oc_req_valid  in  OC_NUM  collector n has a pending read request
- oc_src1_valid  in  OC_NUM  src1 needs reading
- oc_src2_valid  in  OC_NUM  src2 needs reading
- oc_src1_bank  in  OC_NUM*log2(NUM_BANKS)  src1 bank, packed, collector 0 in LSBs
- oc_src2_bank  in  OC_NUM*log2(NUM_BANKS)  src2 bank, packed
- oc_src1_row  in  OC_NUM*ROW_W  src1 physical row, packed
- oc_src2_row  in  OC_NUM*ROW_W  src2 physical row, packed
- oc_grant  out  OC_NUM  one-hot, 1-cycle pulse: all sources of collector n enqueued
- bank_push  out  NUM_BANKS  push strobe per bank queue
- bank_push_data  out  NUM_BANKS*(1+OCID_W+ROW_W)  {same, ocid, row} per bank
- bank_pop  in  NUM_BANKS  queue entry consumed (credit return)
- credit_err  out  1  sticky: pop received with credit already at QDEPTH

Behaviour:
- Reset values: oc_grant=0, bank_push=0, bank_push_data=0, credit_err=0, all credits=QDEPTH, rr_ptr=0, state=IDLE. Reset mid-SECOND abandons the request with no grant.
- Eligible collector: oc_req_valid=1 and at least one srcN_valid=1.
- req_valid with both src valids low: never granted; the collector must not present it.
- Arbitration: round-robin, searching from rr_ptr upward with wrap. Evaluated only in IDLE.
- On grant, rr_ptr <= winner+1 mod OC_NUM. rr_ptr holds while a winner is blocked.
- IDLE, winner with a single valid source: push when that bank's credit >= 1; pulse oc_grant the same cycle; same=0.
- IDLE, two valid sources in different banks: push both the same cycle only if both credits >= 1; otherwise push neither and retry.
- IDLE, two valid sources in the same bank: push src1 with same=0 when credit >= 1, latch winner and src2, go to SECOND. No grant yet.
- SECOND: push latched src2 with same=1 once credit >= 1, pulse oc_grant, go to IDLE. No arbitration in SECOND.
- Collectors hold their request stable until granted.
- Grant/push latency: combinational from request and credit state in the grant cycle, 1 cycle for the same-bank case.
- A blocked winner stalls the arbiter (no skipping): this gives in-order fairness.
- Credits, per bank, ceil(log2(QDEPTH+1)) bits:
  - push without pop: -1; pop without push: +1; push and pop same cycle: unchanged.
  - Pop with credit==QDEPTH: credit stays QDEPTH and credit_err is set until reset.
  - Push at credit 0 cannot occur by construction.
- bank_push_data for a non-pushed bank is 0.

Optional Feature:
- Macro RF_BANK_SCHED_STATS_EN.
- When defined, adds two 32-bit saturating outputs:
  - stall_cycles: cycles with an eligible collector but no push.
  - conflict_cycles: cycles spent in SECOND.
- When undefined, neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Shared package rf_sched_pkg:
  - NUM_BANKS, QDEPTH, ROW_W, OCID_W.
  - Queue entry typedef {same, ocid, row}.
  - State enum {IDLE, SECOND}.
- Sub-module rr_arbiter: OC_NUM-wide request vector plus pointer in, one-hot winner plus valid out, purely combinational. Instantiated once.
- Credit counters and FSM stay in the top.

Test Plan:
- Reset, then collector 2 with src1 bank1/row5 and src2 bank3/row2 -> same cycle: bank_push=4'b1010, bank1 data {0,2,5}, bank3 data {0,2,2}, oc_grant=4'b0100, credits bank1/bank3 = 7.
- Collector 0 with both sources in bank 2 (rows 1 and 6) -> cycle 0 push {0,0,1}, no grant; cycle 1 push {1,0,6} and oc_grant=4'b0001; bank2 credit=6.
- All 4 collectors requesting continuously, single sources in distinct banks, no pops -> grants in order 0,1,2,3,0...
- Eight pushes to bank 0 with no pops -> ninth request blocks and arbiter stalls; one bank_pop[0] -> push resumes the next cycle.
- Push and pop on bank 0 in the same cycle at credit 3 -> credit stays 3.
- Pop on bank 1 at credit 8 -> credit_err=1 and remains 1.
- rst asserted in SECOND -> next cycle: no grant, credits all 8, rr_ptr=0, state IDLE.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared types and sizing for the RF bank request scheduler: queue entry layout,
// scheduler state encoding and the per-bank credit update rule.
package rf_sched_pkg;

    localparam int NUM_BANKS = 4;
    localparam int QDEPTH    = 8;
    localparam int ROW_W     = 3;
    localparam int OCID_W    = 3;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int CRED_W    = $clog2(QDEPTH + 1);
    localparam int ENTRY_W   = 1 + OCID_W + ROW_W;

    typedef struct packed {
        logic              same;
        logic [OCID_W-1:0] ocid;
        logic [ROW_W-1:0]  row;
    } q_entry_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } sched_state_t;

    // A simultaneous push and pop cancel; a pop at full credit is absorbed.
    function automatic logic [CRED_W-1:0] credit_next(
        input logic [CRED_W-1:0] cur,
        input logic              push,
        input logic              pop
    );
        logic [CRED_W-1:0] nxt;
        nxt = cur;
        if (push && !pop) begin
            nxt = cur - 1'b1;
        end else if (pop && !push && (cur != CRED_W'(QDEPTH))) begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rf_bank_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above i_ptr, with wrap.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_valid
);

    always_comb begin
        logic [PTR_W:0]   w_sum;
        logic [PTR_W-1:0] w_idx;
        o_grant = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= (PTR_W + 1)'(N)) begin
                w_sum = w_sum - (PTR_W + 1)'(N);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_bank_req_scheduler.sv
// Operand-read scheduler: arbitrates collectors and steers source reads into credit-tracked
// per-bank queues. Optional counters stall_cycles/conflict_cycles under RF_BANK_SCHED_STATS_EN.
module rf_bank_req_scheduler
    import rf_sched_pkg::*;
#(
    parameter int OC_NUM = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [OC_NUM-1:0]             oc_req_valid,
    input  logic [OC_NUM-1:0]             oc_src1_valid,
    input  logic [OC_NUM-1:0]             oc_src2_valid,
    input  logic [OC_NUM*BANK_W-1:0]      oc_src1_bank,
    input  logic [OC_NUM*BANK_W-1:0]      oc_src2_bank,
    input  logic [OC_NUM*ROW_W-1:0]       oc_src1_row,
    input  logic [OC_NUM*ROW_W-1:0]       oc_src2_row,
    output logic [OC_NUM-1:0]             oc_grant,
    output logic [NUM_BANKS-1:0]          bank_push,
    output logic [NUM_BANKS*ENTRY_W-1:0]  bank_push_data,
    input  logic [NUM_BANKS-1:0]          bank_pop,
    output logic                          credit_err,
    output sched_state_t                  dbg_state,
    output logic [$clog2(OC_NUM)-1:0]     dbg_rr_ptr,
    output logic [NUM_BANKS*CRED_W-1:0]   dbg_credit
`ifdef RF_BANK_SCHED_STATS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   conflict_cycles
`endif
);

    localparam int PTR_W = $clog2(OC_NUM);

    sched_state_t      r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [CRED_W-1:0] r_credit [NUM_BANKS];
    logic              r_credit_err;
    logic [OC_NUM-1:0] r_win_oh;
    logic [PTR_W-1:0]  r_win_idx;
    logic [BANK_W-1:0] r_s2_bank;
    logic [ROW_W-1:0]  r_s2_row;

    logic [OC_NUM-1:0]    w_elig;
    logic [OC_NUM-1:0]    w_win_oh;
    logic                 w_win_vld;
    logic [PTR_W-1:0]     w_win_idx;
    logic                 w_s1v, w_s2v;
    logic [BANK_W-1:0]    w_s1b, w_s2b;
    logic [ROW_W-1:0]     w_s1r, w_s2r;
    logic [NUM_BANKS-1:0] w_has_credit;
    logic [NUM_BANKS-1:0] w_push;
    q_entry_t             w_entry [NUM_BANKS];
    logic [OC_NUM-1:0]    w_grant;
    logic                 w_fire;
    logic                 w_enter_second;
    logic [PTR_W-1:0]     w_gnt_idx;

    assign w_elig = oc_req_valid & (oc_src1_valid | oc_src2_valid);

    rr_arbiter #(
        .N     (OC_NUM),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_win_oh),
        .o_valid (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        w_s1v     = 1'b0;
        w_s2v     = 1'b0;
        w_s1b     = '0;
        w_s2b     = '0;
        w_s1r     = '0;
        w_s2r     = '0;
        for (int n = 0; n < OC_NUM; n++) begin
            if (w_win_oh[n]) begin
                w_win_idx = PTR_W'(n);
                w_s1v     = oc_src1_valid[n];
                w_s2v     = oc_src2_valid[n];
                w_s1b     = oc_src1_bank[n*BANK_W +: BANK_W];
                w_s2b     = oc_src2_bank[n*BANK_W +: BANK_W];
                w_s1r     = oc_src1_row[n*ROW_W +: ROW_W];
                w_s2r     = oc_src2_row[n*ROW_W +: ROW_W];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_has_credit[b] = (r_credit[b] != '0);
        end
    end

    // Push/grant decision; nothing is issued while reset is asserted.
    always_comb begin
        w_push         = '0;
        w_grant        = '0;
        w_fire         = 1'b0;
        w_enter_second = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_entry[b] = '0;
        end
        if (!rst) begin
            if (r_state == IDLE && w_win_vld) begin
                if (w_s1v && w_s2v && (w_s1b == w_s2b)) begin
                    if (w_has_credit[w_s1b]) begin
                        w_push[w_s1b]  = 1'b1;
                        w_entry[w_s1b] = '{same: 1'b0, ocid: OCID_W'(w_win_idx), row: w_s1r};
                        w_enter_second = 1'b1;
                    end
                end else if (w_s1v && w_s2v) begin
                    if (w_has_credit[w_s1b] && w_has_credit[w_s2b]) begin
                        w_push[w_s1b]  = 1'b1;
                        w_push[w_s2b]  = 1'b1;
                        w_entry[w_s1b] = '{same: 1'b0, ocid: OCID_W'(w_win_idx), row: w_s1r};
                        w_entry[w_s2b] = '{same: 1'b0, ocid: OCID_W'(w_win_idx), row: w_s2r};
                        w_grant        = w_win_oh;
                        w_fire         = 1'b1;
                    end
                end else if (w_s1v) begin
                    if (w_has_credit[w_s1b]) begin
                        w_push[w_s1b]  = 1'b1;
                        w_entry[w_s1b] = '{same: 1'b0, ocid: OCID_W'(w_win_idx), row: w_s1r};
                        w_grant        = w_win_oh;
                        w_fire         = 1'b1;
                    end
                end else if (w_s2v) begin
                    if (w_has_credit[w_s2b]) begin
                        w_push[w_s2b]  = 1'b1;
                        w_entry[w_s2b] = '{same: 1'b0, ocid: OCID_W'(w_win_idx), row: w_s2r};
                        w_grant        = w_win_oh;
                        w_fire         = 1'b1;
                    end
                end
            end else if (r_state == SECOND) begin
                if (w_has_credit[r_s2_bank]) begin
                    w_push[r_s2_bank]  = 1'b1;
                    w_entry[r_s2_bank] = '{same: 1'b1, ocid: OCID_W'(r_win_idx), row: r_s2_row};
                    w_grant            = r_win_oh;
                    w_fire             = 1'b1;
                end
            end
        end
    end

    assign w_gnt_idx = (r_state == SECOND) ? r_win_idx : w_win_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_credit_err <= 1'b0;
            r_win_oh     <= '0;
            r_win_idx    <= '0;
            r_s2_bank    <= '0;
            r_s2_row     <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_credit[b] <= CRED_W'(QDEPTH);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_enter_second) begin
                        r_state   <= SECOND;
                        r_win_oh  <= w_win_oh;
                        r_win_idx <= w_win_idx;
                        r_s2_bank <= w_s2b;
                        r_s2_row  <= w_s2r;
                    end
                end
                SECOND: begin
                    if (w_fire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_fire) begin
                r_rr_ptr <= (w_gnt_idx == PTR_W'(OC_NUM - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_credit[b] <= credit_next(r_credit[b], w_push[b], bank_pop[b]);
                if (bank_pop[b] && !w_push[b] && (r_credit[b] == CRED_W'(QDEPTH))) begin
                    r_credit_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bank_push_data = '0;
        dbg_credit     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_push_data[b*ENTRY_W +: ENTRY_W] = w_entry[b];
            dbg_credit[b*CRED_W +: CRED_W]       = r_credit[b];
        end
    end

    assign oc_grant   = w_grant;
    assign bank_push  = w_push;
    assign credit_err = r_credit_err;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

`ifdef RF_BANK_SCHED_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_conflict_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles    <= '0;
            r_conflict_cycles <= '0;
        end else begin
            if ((|w_elig) && !(|w_push) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if ((r_state == SECOND) && (r_conflict_cycles != '1)) begin
                r_conflict_cycles <= r_conflict_cycles + 1'b1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign conflict_cycles = r_conflict_cycles;
`endif

endmodule

// File: tb/tb_rf_bank_req_scheduler.sv
// Self-checking bench for rf_bank_req_scheduler: vector table plus hand-written sequences.
module tb_rf_bank_req_scheduler;
  import rf_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  oc_req_valid, oc_src1_valid, oc_src2_valid;
  logic [7:0]  oc_src1_bank, oc_src2_bank;
  logic [11:0] oc_src1_row, oc_src2_row;
  logic [3:0]  oc_grant;
  logic [3:0]  bank_push;
  logic [27:0] bank_push_data;
  logic [3:0]  bank_pop;
  logic        credit_err;
  sched_state_t dbg_state;
  logic [1:0]  dbg_rr_ptr;
  logic [15:0] dbg_credit;

  rf_bank_req_scheduler #(.OC_NUM(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .oc_req_valid   (oc_req_valid),
    .oc_src1_valid  (oc_src1_valid),
    .oc_src2_valid  (oc_src2_valid),
    .oc_src1_bank   (oc_src1_bank),
    .oc_src2_bank   (oc_src2_bank),
    .oc_src1_row    (oc_src1_row),
    .oc_src2_row    (oc_src2_row),
    .oc_grant       (oc_grant),
    .bank_push      (bank_push),
    .bank_push_data (bank_push_data),
    .bank_pop       (bank_pop),
    .credit_err     (credit_err),
    .dbg_state      (dbg_state),
    .dbg_rr_ptr     (dbg_rr_ptr),
    .dbg_credit     (dbg_credit)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [35:0] exp_q[$];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic sb_check(input string name);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      chk({name, " queue"}, 36'd1, 36'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, " grant"}, 36'(oc_grant), 36'(e[35:32]));
      chk({name, " push"}, 36'(bank_push), 36'(e[31:28]));
      chk({name, " data"}, 36'(bank_push_data), 36'(e[27:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    oc_req_valid  = '0;
    oc_src1_valid = '0;
    oc_src2_valid = '0;
    oc_src1_bank  = '0;
    oc_src2_bank  = '0;
    oc_src1_row   = '0;
    oc_src2_row   = '0;
    bank_pop      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs at negedge, queue the expectation, sample 1ns later.
  task automatic drive(input logic [3:0] req, input logic [3:0] s1v, input logic [3:0] s2v,
                       input logic [7:0] s1b, input logic [7:0] s2b,
                       input logic [11:0] s1r, input logic [11:0] s2r, input logic [3:0] pop,
                       input logic [3:0] e_grant, input logic [3:0] e_push,
                       input logic [27:0] e_data, input string name);
    @(negedge clk);
    oc_req_valid  = req;
    oc_src1_valid = s1v;
    oc_src2_valid = s2v;
    oc_src1_bank  = s1b;
    oc_src2_bank  = s2b;
    oc_src1_row   = s1r;
    oc_src2_row   = s2r;
    bank_pop      = pop;
    exp_q.push_back({e_grant, e_push, e_data});
    #1;
    sb_check(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req, s1v, s2v;
    logic [7:0]  s1b, s2b;
    logic [11:0] s1r, s2r;
    logic [3:0]  pop;
    logic [3:0]  grant, push;
    logic [27:0] data;
    logic [15:0] cred;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] s1v, input logic [3:0] s2v,
                              input logic [7:0] s1b, input logic [7:0] s2b,
                              input logic [11:0] s1r, input logic [11:0] s2r,
                              input logic [3:0] pop, input logic [3:0] grant,
                              input logic [3:0] push, input logic [27:0] data,
                              input logic [15:0] cred, input logic err);
    vec_t v;
    v.req = req; v.s1v = s1v; v.s2v = s2v; v.s1b = s1b; v.s2b = s2b;
    v.s1r = s1r; v.s2r = s2r; v.pop = pop; v.grant = grant; v.push = push;
    v.data = data; v.cred = cred; v.err = err;
    return v;
  endfunction

  vec_t tbl[8];

  initial begin
    logic [27:0] d;
    int w;

    tbl[0] = mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0000,
                4'b0000, 4'b0000, 28'h0, 16'h8888, 1'b0);
    tbl[1] = mk(4'b0100, 4'b0100, 4'b0100, 8'h10, 8'h30, 12'h140, 12'h080, 4'b0000,
                4'b0100, 4'b1010, {7'h12, 7'h00, 7'h15, 7'h00}, 16'h8888, 1'b0);
    tbl[2] = mk(4'b0001, 4'b0001, 4'b0001, 8'h02, 8'h02, 12'h001, 12'h006, 4'b0000,
                4'b0000, 4'b0100, {7'h00, 7'h01, 7'h00, 7'h00}, 16'h7878, 1'b0);
    tbl[3] = mk(4'b0001, 4'b0001, 4'b0001, 8'h02, 8'h02, 12'h001, 12'h006, 4'b0000,
                4'b0001, 4'b0100, {7'h00, 7'h46, 7'h00, 7'h00}, 16'h7778, 1'b0);
    tbl[4] = mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b1110,
                4'b0000, 4'b0000, 28'h0, 16'h7678, 1'b0);
    tbl[5] = mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0100,
                4'b0000, 4'b0000, 28'h0, 16'h8788, 1'b0);
    tbl[6] = mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0010,
                4'b0000, 4'b0000, 28'h0, 16'h8888, 1'b0);
    tbl[7] = mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0000,
                4'b0000, 4'b0000, 28'h0, 16'h8888, 1'b1);

    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset state", 36'(dbg_state), 36'(IDLE));
    chk("reset rr_ptr", 36'(dbg_rr_ptr), 36'd0);
    chk("reset err", 36'(credit_err), 36'd0);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].req, tbl[i].s1v, tbl[i].s2v, tbl[i].s1b, tbl[i].s2b, tbl[i].s1r,
            tbl[i].s2r, tbl[i].pop, tbl[i].grant, tbl[i].push, tbl[i].data,
            $sformatf("vec%0d", i));
      chk($sformatf("vec%0d credit", i), 36'(dbg_credit), 36'(tbl[i].cred));
      chk($sformatf("vec%0d err", i), 36'(credit_err), 36'(tbl[i].err));
    end
    chk("table rr_ptr", 36'(dbg_rr_ptr), 36'd1);
    chk("table state", 36'(dbg_state), 36'(IDLE));
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0000,
          4'b0000, 4'b0000, 28'h0, "err sticky");
    chk("err sticky", 36'(credit_err), 36'd1);

    // Round-robin: all four collectors, single source each into its own bank.
    do_reset();
    #1;
    chk("rr err cleared", 36'(credit_err), 36'd0);
    for (int k = 0; k < 8; k++) begin
      w = k % 4;
      d = '0;
      d[w*7 +: 7] = {1'b0, 3'(w), 3'(w)};
      drive(4'b1111, 4'b1111, 4'b0000, 8'hE4, 8'h00, 12'h688, 12'h000, 4'b0000,
            4'(1 << w), 4'(1 << w), d, $sformatf("rr%0d", k));
    end
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0000,
          4'b0000, 4'b0000, 28'h0, "rr idle");
    chk("rr credits", 36'(dbg_credit), 36'h6666);

    // Exhaust bank 0, observe the stall, then a pop releases it.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00, 12'h007, 12'h000, 4'b0000,
            4'b0001, 4'b0001, 28'h7, $sformatf("fill%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00, 12'h007, 12'h000, 4'b0000,
            4'b0000, 4'b0000, 28'h0, $sformatf("blocked%0d", k));
      chk($sformatf("blocked%0d credit", k), 36'(dbg_credit[3:0]), 36'd0);
    end
    chk("blocked rr_ptr", 36'(dbg_rr_ptr), 36'd1);
    drive(4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00, 12'h007, 12'h000, 4'b0001,
          4'b0000, 4'b0000, 28'h0, "pop cycle");
    drive(4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00, 12'h007, 12'h000, 4'b0000,
          4'b0001, 4'b0001, 28'h7, "resume");
    chk("resume credit", 36'(dbg_credit[3:0]), 36'd1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0001,
            4'b0000, 4'b0000, 28'h0, $sformatf("refill%0d", k));
    end
    drive(4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00, 12'h007, 12'h000, 4'b0001,
          4'b0001, 4'b0001, 28'h7, "push+pop");
    chk("push+pop credit before", 36'(dbg_credit[3:0]), 36'd3);
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 12'h000, 12'h000, 4'b0000,
          4'b0000, 4'b0000, 28'h0, "push+pop after");
    chk("push+pop credit after", 36'(dbg_credit[3:0]), 36'd3);
    chk("push+pop err", 36'(credit_err), 36'd0);

    // Reset while waiting in SECOND abandons the request.
    do_reset();
    drive(4'b0001, 4'b0001, 4'b0001, 8'h02, 8'h02, 12'h001, 12'h006, 4'b0000,
          4'b0000, 4'b0100, {7'h00, 7'h01, 7'h00, 7'h00}, "second entry");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back({4'b0000, 4'b0000, 28'h0});
    #1;
    chk("in second state", 36'(dbg_state), 36'(SECOND));
    sb_check("rst in second");
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    exp_q.push_back({4'b0000, 4'b0000, 28'h0});
    #1;
    sb_check("after rst");
    chk("after rst credits", 36'(dbg_credit), 36'h8888);
    chk("after rst rr_ptr", 36'(dbg_rr_ptr), 36'd0);
    chk("after rst state", 36'(dbg_state), 36'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
